pic_cmd_sequencer: RTL and testbench

Host-side controller that programs the 8259A-compatible PIC through its CPU bus port (CS_n, WR_n, A0, D[7:0]).
- On request, it issues the ICW1..ICW4 initialization sequence built from a configuration snapshot.
- After initialization, it accepts single OCW1/OCW2/OCW3 write requests over a req/ack handshake.
- It generates bus timing with programmable setup, strobe and recovery lengths.
- It sits between the system controller/firmware-replacement logic and the PIC bus interface.

---
 rtl/pic_cmd_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_pic_cmd_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_cmd_sequencer.sv
// Host-side programmer for an 8259A-compatible PIC: issues the ICW1..ICW4 init
// sequence and single OCW writes over the PIC CPU bus with programmable timing.
module pic_cmd_sequencer #(
    parameter int unsigned SETUP_CYCLES    = 1,
    parameter int unsigned WR_LOW_CYCLES   = 2,
    parameter int unsigned RECOVERY_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       init_start,
    input  logic       cfg_ltim,
    input  logic       cfg_sngl,
    input  logic       cfg_ic4,
    input  logic [4:0] cfg_vec_base,
    input  logic [7:0] cfg_cascade,
    input  logic       cfg_aeoi,
    input  logic       cfg_upm,
    input  logic       ocw_req,
    input  logic [1:0] ocw_sel,
    input  logic [7:0] ocw_data,
    output logic       ocw_ack,
    output logic       ocw_err,
    output logic       busy,
    output logic       initialized,
    output logic       init_done,
    output logic       pic_cs_n,
    output logic       pic_wr_n,
    output logic       pic_a0,
    output logic [7:0] pic_data,
    output logic       pic_data_oe
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LD   = CNT_W'(RECOVERY_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RECOVER
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             init_mode_q, init_mode_d;
    logic [1:0]       idx_q, idx_d;
    logic             pending_q, pending_d;
    logic             sngl_q, sngl_d, ic4_q, ic4_d, aeoi_q, aeoi_d, upm_q, upm_d;
    logic [4:0]       vec_q, vec_d;
    logic [7:0]       casc_q, casc_d;
    logic             ack_q, ack_d, err_q, err_d, busy_q, busy_d;
    logic             initialized_q, initialized_d, init_done_q, init_done_d;
    logic             cs_n_q, cs_n_d, wr_n_q, wr_n_d, a0_q, a0_d, oe_q, oe_d;
    logic [7:0]       data_q, data_d;
    logic             has_next;
    logic [1:0]       next_idx;
    logic [7:0]       next_word;

    // Successor of the current init word, skipping ICW3/ICW4 per the snapshot.
    always_comb begin
        has_next  = 1'b0;
        next_idx  = 2'd0;
        next_word = 8'h00;
        case (idx_q)
            2'd0: begin
                has_next = 1'b1;
                next_idx = 2'd1;
            end
            2'd1: begin
                if (!sngl_q) begin
                    has_next = 1'b1;
                    next_idx = 2'd2;
                end else if (ic4_q) begin
                    has_next = 1'b1;
                    next_idx = 2'd3;
                end
            end
            2'd2: begin
                has_next = ic4_q;
                next_idx = 2'd3;
            end
            default: has_next = 1'b0;
        endcase
        case (next_idx)
            2'd1:    next_word = {vec_q, 3'b000};
            2'd2:    next_word = casc_q;
            2'd3:    next_word = {6'b000000, aeoi_q, upm_q};
            default: next_word = 8'h00;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        init_mode_d   = init_mode_q;
        idx_d         = idx_q;
        pending_d     = pending_q;
        sngl_d        = sngl_q;
        ic4_d         = ic4_q;
        aeoi_d        = aeoi_q;
        upm_d         = upm_q;
        vec_d         = vec_q;
        casc_d        = casc_q;
        ack_d         = 1'b0;
        err_d         = 1'b0;
        init_done_d   = 1'b0;
        initialized_d = initialized_q;
        a0_d          = a0_q;
        data_d        = data_q;

        if (init_start && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (init_start || pending_q) begin
                    pending_d     = 1'b0;
                    initialized_d = 1'b0;
                    init_mode_d   = 1'b1;
                    idx_d         = 2'd0;
                    sngl_d        = cfg_sngl;
                    ic4_d         = cfg_ic4;
                    aeoi_d        = cfg_aeoi;
                    upm_d         = cfg_upm;
                    vec_d         = cfg_vec_base;
                    casc_d        = cfg_cascade;
                    state_d       = S_SETUP;
                    cnt_d         = SETUP_LD;
                    a0_d          = 1'b0;
                    data_d        = {3'b000, 1'b1, cfg_ltim, 1'b0, cfg_sngl, cfg_ic4};
                end else if (ocw_req && !ack_q && !err_q) begin
                    // A request still high right after its ack/err is not a new one.
                    if (initialized_q && (ocw_sel != 2'd0)) begin
                        ack_d       = 1'b1;
                        init_mode_d = 1'b0;
                        state_d     = S_SETUP;
                        cnt_d       = SETUP_LD;
                        case (ocw_sel)
                            2'd1: begin
                                a0_d   = 1'b1;
                                data_d = ocw_data;
                            end
                            2'd2: begin
                                a0_d   = 1'b0;
                                data_d = {ocw_data[7:5], 2'b00, ocw_data[2:0]};
                            end
                            default: begin
                                a0_d   = 1'b0;
                                data_d = {1'b0, ocw_data[6:5], 2'b01, ocw_data[2:0]};
                            end
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE;
                    cnt_d   = WR_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                state_d = S_RECOVER;
                cnt_d   = REC_LD;
            end
            S_RECOVER: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (init_mode_q && has_next) begin
                    idx_d   = next_idx;
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                    a0_d    = 1'b1;
                    data_d  = next_word;
                end else begin
                    state_d = S_IDLE;
                    if (init_mode_q) begin
                        init_done_d   = 1'b1;
                        initialized_d = 1'b1;
                        init_mode_d   = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus pins are registered decodes of the upcoming state.
        cs_n_d = !((state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD));
        oe_d   = !cs_n_d;
        wr_n_d = (state_d != S_STROBE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            init_mode_q   <= 1'b0;
            idx_q         <= 2'd0;
            pending_q     <= 1'b0;
            sngl_q        <= 1'b0;
            ic4_q         <= 1'b0;
            aeoi_q        <= 1'b0;
            upm_q         <= 1'b0;
            vec_q         <= '0;
            casc_q        <= '0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            initialized_q <= 1'b0;
            init_done_q   <= 1'b0;
            cs_n_q        <= 1'b1;
            wr_n_q        <= 1'b1;
            a0_q          <= 1'b0;
            data_q        <= 8'h00;
            oe_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            init_mode_q   <= init_mode_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            sngl_q        <= sngl_d;
            ic4_q         <= ic4_d;
            aeoi_q        <= aeoi_d;
            upm_q         <= upm_d;
            vec_q         <= vec_d;
            casc_q        <= casc_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            initialized_q <= initialized_d;
            init_done_q   <= init_done_d;
            cs_n_q        <= cs_n_d;
            wr_n_q        <= wr_n_d;
            a0_q          <= a0_d;
            data_q        <= data_d;
            oe_q          <= oe_d;
        end
    end

    assign ocw_ack     = ack_q;
    assign ocw_err     = err_q;
    assign busy        = busy_q;
    assign initialized = initialized_q;
    assign init_done   = init_done_q;
    assign pic_cs_n    = cs_n_q;
    assign pic_wr_n    = wr_n_q;
    assign pic_a0      = a0_q;
    assign pic_data    = data_q;
    assign pic_data_oe = oe_q;

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Self-checking bench for pic_cmd_sequencer: a bus monitor pops expected
// {a0,data} words from a scoreboard queue at every write strobe.
module tb_pic_cmd_sequencer;

    logic       clk;
    logic       reset_n;
    logic       init_start;
    logic       cfg_ltim, cfg_sngl, cfg_ic4, cfg_aeoi, cfg_upm;
    logic [4:0] cfg_vec_base;
    logic [7:0] cfg_cascade;
    logic       ocw_req;
    logic [1:0] ocw_sel;
    logic [7:0] ocw_data;
    logic       ocw_ack, ocw_err, busy, initialized, init_done;
    logic       pic_cs_n, pic_wr_n, pic_a0, pic_data_oe;
    logic [7:0] pic_data;

    int total = 0;
    int bad = 0;
    int strobes = 0;
    logic [8:0] exp_q[$];

    pic_cmd_sequencer dut (
        .clk(clk), .reset_n(reset_n), .init_start(init_start),
        .cfg_ltim(cfg_ltim), .cfg_sngl(cfg_sngl), .cfg_ic4(cfg_ic4),
        .cfg_vec_base(cfg_vec_base), .cfg_cascade(cfg_cascade),
        .cfg_aeoi(cfg_aeoi), .cfg_upm(cfg_upm),
        .ocw_req(ocw_req), .ocw_sel(ocw_sel), .ocw_data(ocw_data),
        .ocw_ack(ocw_ack), .ocw_err(ocw_err), .busy(busy),
        .initialized(initialized), .init_done(init_done),
        .pic_cs_n(pic_cs_n), .pic_wr_n(pic_wr_n), .pic_a0(pic_a0),
        .pic_data(pic_data), .pic_data_oe(pic_data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus monitor: checks each strobe's word, strobe length and hold stability.
    initial begin : monitor
        int low_cnt;
        logic [8:0] first_word;
        logic [8:0] w;
        low_cnt = 0;
        first_word = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                low_cnt = 0;
            end else if (!pic_wr_n) begin
                if (low_cnt == 0) begin
                    strobes++;
                    first_word = {pic_a0, pic_data};
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_write got=%h need=none", first_word);
                    end else begin
                        w = exp_q.pop_front();
                        if (first_word !== w) begin
                            bad++;
                            $display("FAIL write_word got=%h need=%h", first_word, w);
                        end
                    end
                    total++;
                    if (pic_cs_n !== 1'b0 || pic_data_oe !== 1'b1) begin
                        bad++;
                        $display("FAIL strobe_bus cs_n=%b oe=%b need cs_n=0 oe=1", pic_cs_n, pic_data_oe);
                    end
                end
                low_cnt++;
            end else if (low_cnt != 0) begin
                total++;
                if (low_cnt != 2) begin
                    bad++;
                    $display("FAIL wr_low_len got=%0d need=2", low_cnt);
                end
                total++;
                if ({pic_a0, pic_data} !== first_word || pic_cs_n !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_stable got=%h cs_n=%b need=%h cs_n=0", {pic_a0, pic_data}, pic_cs_n, first_word);
                end
                low_cnt = 0;
            end
        end
    end

    task automatic set_cfg(input logic ltim, input logic sngl, input logic ic4,
                           input logic [4:0] vec, input logic [7:0] casc,
                           input logic aeoi, input logic upm);
        cfg_ltim = ltim; cfg_sngl = sngl; cfg_ic4 = ic4; cfg_vec_base = vec;
        cfg_cascade = casc; cfg_aeoi = aeoi; cfg_upm = upm;
    endtask

    task automatic pulse_init();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
    endtask

    task automatic drain(output int n, output int dones, output int acks);
        n = 0; dones = 0; acks = 0;
        while (busy === 1'b1 && n < 200) begin
            if (init_done === 1'b1) dones++;
            if (ocw_ack === 1'b1 && n > 0) acks++;
            n++;
            tick();
        end
    endtask

    task automatic send_ocw(input logic [1:0] sel, input logic [7:0] d,
                            output logic a, output logic e, output logic b,
                            output logic cs, output int n);
        ocw_sel = sel; ocw_data = d; ocw_req = 1'b1; n = 0;
        do begin
            tick();
            n++;
        end while (!(ocw_ack === 1'b1 || ocw_err === 1'b1) && n < 20);
        a = ocw_ack; e = ocw_err; b = busy; cs = pic_cs_n;
        ocw_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({pic_cs_n, pic_wr_n, pic_a0, pic_data, pic_data_oe} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_bus got cs=%b wr=%b a0=%b d=%h oe=%b need 1 1 0 00 0", pic_cs_n, pic_wr_n, pic_a0, pic_data, pic_data_oe);
        end
        total++;
        if ({busy, initialized, ocw_ack, ocw_err, init_done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_status got=%b need=00000", {busy, initialized, ocw_ack, ocw_err, init_done});
        end
        reset_n = 1'b1;
        repeat (2) tick();
        total++;
        if (pic_cs_n !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle cs_n=%b busy=%b need 1 0", pic_cs_n, busy);
        end
    endtask

    task automatic test_ocw_before_init();
        logic a, e, b, cs;
        int n;
        int extra = 0;
        int cs_low = 0;
        send_ocw(2'd1, 8'hFE, a, e, b, cs, n);
        total++;
        if (n !== 1 || a !== 1'b0 || e !== 1'b1 || b !== 1'b0 || cs !== 1'b1) begin
            bad++;
            $display("FAIL ocw_pre_init lat=%0d ack=%b err=%b busy=%b cs_n=%b need 1 0 1 0 1", n, a, e, b, cs);
        end
        repeat (8) begin
            tick();
            if (ocw_ack === 1'b1 || ocw_err === 1'b1) extra++;
            if (pic_cs_n !== 1'b1) cs_low++;
        end
        total++;
        if (extra != 0 || cs_low != 0) begin
            bad++;
            $display("FAIL ocw_pre_init_quiet pulses=%0d cs_low=%0d need 0 0", extra, cs_low);
        end
    endtask

    task automatic test_init_single();
        int n, dones, acks;
        set_cfg(1'b0, 1'b1, 1'b1, 5'h11, 8'h00, 1'b1, 1'b1);
        exp_q.push_back({1'b0, 8'h13});
        exp_q.push_back({1'b1, 8'h88});
        exp_q.push_back({1'b1, 8'h03});
        pulse_init();
        total++;
        if (busy !== 1'b1 || pic_cs_n !== 1'b0 || init_done !== 1'b0) begin
            bad++;
            $display("FAIL init1_start busy=%b cs_n=%b done=%b need 1 0 0", busy, pic_cs_n, init_done);
        end
        drain(n, dones, acks);
        total++;
        if (n != 18 || dones != 0) begin
            bad++;
            $display("FAIL init1_busy_len got=%0d early_done=%0d need 18 0", n, dones);
        end
        total++;
        if (init_done !== 1'b1 || initialized !== 1'b1) begin
            bad++;
            $display("FAIL init1_done done=%b init=%b need 1 1", init_done, initialized);
        end
        tick();
        total++;
        if (init_done !== 1'b0 || initialized !== 1'b1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL init1_after done=%b init=%b left=%0d need 0 1 0", init_done, initialized, exp_q.size());
        end
    endtask

    task automatic test_init_cascade();
        int n, dones, acks;
        set_cfg(1'b1, 1'b0, 1'b0, 5'h05, 8'h04, 1'b1, 1'b1);
        exp_q.push_back({1'b0, 8'h18});
        exp_q.push_back({1'b1, 8'h28});
        exp_q.push_back({1'b1, 8'h04});
        pulse_init();
        total++;
        if (initialized !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL init2_clear init=%b busy=%b need 0 1", initialized, busy);
        end
        drain(n, dones, acks);
        total++;
        if (n != 18 || init_done !== 1'b1 || initialized !== 1'b1) begin
            bad++;
            $display("FAIL init2_done len=%0d done=%b init=%b need 18 1 1", n, init_done, initialized);
        end
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL init2_words left=%0d need 0", exp_q.size());
        end
    endtask

    task automatic test_ocw_after_init();
        logic a, e, b, cs;
        int n, dones, acks;
        exp_q.push_back({1'b1, 8'hFE});
        send_ocw(2'd1, 8'hFE, a, e, b, cs, n);
        total++;
        if (n !== 1 || a !== 1'b1 || e !== 1'b0 || b !== 1'b1 || cs !== 1'b0) begin
            bad++;
            $display("FAIL ocw1_accept lat=%0d ack=%b err=%b busy=%b cs_n=%b need 1 1 0 1 0", n, a, e, b, cs);
        end
        drain(n, dones, acks);
        total++;
        if (n != 6 || acks != 0) begin
            bad++;
            $display("FAIL ocw1_len got=%0d extra_acks=%0d need 6 0", n, acks);
        end
        tick();
        total++;
        if (exp_q.size() != 0 || ocw_ack !== 1'b0 || pic_cs_n !== 1'b1) begin
            bad++;
            $display("FAIL ocw1_after left=%0d ack=%b cs_n=%b need 0 0 1", exp_q.size(), ocw_ack, pic_cs_n);
        end
    endtask

    task automatic test_ocw_formats();
        logic a, e, b, cs;
        int n, dones, acks;
        exp_q.push_back({1'b0, 8'hE7});
        send_ocw(2'd2, 8'hFF, a, e, b, cs, n);
        total++;
        if (a !== 1'b1 || e !== 1'b0) begin
            bad++;
            $display("FAIL ocw2_accept ack=%b err=%b need 1 0", a, e);
        end
        drain(n, dones, acks);
        exp_q.push_back({1'b0, 8'h6F});
        send_ocw(2'd3, 8'hFF, a, e, b, cs, n);
        total++;
        if (a !== 1'b1 || e !== 1'b0) begin
            bad++;
            $display("FAIL ocw3_accept ack=%b err=%b need 1 0", a, e);
        end
        drain(n, dones, acks);
        send_ocw(2'd0, 8'h5A, a, e, b, cs, n);
        total++;
        if (a !== 1'b0 || e !== 1'b1 || cs !== 1'b1 || b !== 1'b0) begin
            bad++;
            $display("FAIL ocw_sel0 ack=%b err=%b cs_n=%b busy=%b need 0 1 1 0", a, e, cs, b);
        end
        repeat (8) tick();
        total++;
        if (exp_q.size() != 0 || pic_cs_n !== 1'b1) begin
            bad++;
            $display("FAIL ocw_formats_end left=%0d cs_n=%b need 0 1", exp_q.size(), pic_cs_n);
        end
    endtask

    task automatic test_init_ocw_tie();
        int n, dones, acks;
        set_cfg(1'b0, 1'b1, 1'b1, 5'h11, 8'h00, 1'b1, 1'b1);
        exp_q.push_back({1'b0, 8'h13});
        exp_q.push_back({1'b1, 8'h88});
        exp_q.push_back({1'b1, 8'h03});
        ocw_sel = 2'd1; ocw_data = 8'h55; ocw_req = 1'b1;
        init_start = 1'b1;
        tick();
        init_start = 1'b0; ocw_req = 1'b0;
        total++;
        if (ocw_ack !== 1'b0 || ocw_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL tie_accept ack=%b err=%b busy=%b need 0 0 1", ocw_ack, ocw_err, busy);
        end
        drain(n, dones, acks);
        total++;
        if (n != 18 || acks != 0 || init_done !== 1'b1) begin
            bad++;
            $display("FAIL tie_init len=%0d acks=%0d done=%b need 18 0 1", n, acks, init_done);
        end
        tick();
    endtask

    task automatic test_init_during_ocw();
        logic a, e, b, cs;
        int n, dones, acks;
        int w = 0;
        exp_q.push_back({1'b1, 8'h5A});
        send_ocw(2'd1, 8'h5A, a, e, b, cs, n);
        while (pic_wr_n !== 1'b0 && w < 10) begin
            tick();
            w++;
        end
        total++;
        if (a !== 1'b1 || pic_wr_n !== 1'b0) begin
            bad++;
            $display("FAIL pend_ocw_strobe ack=%b wr_n=%b need 1 0", a, pic_wr_n);
        end
        exp_q.push_back({1'b0, 8'h13});
        exp_q.push_back({1'b1, 8'h88});
        exp_q.push_back({1'b1, 8'h03});
        pulse_init();
        drain(n, dones, acks);
        total++;
        if (busy !== 1'b0 || init_done !== 1'b0 || exp_q.size() != 3) begin
            bad++;
            $display("FAIL pend_gap busy=%b done=%b left=%0d need 0 0 3", busy, init_done, exp_q.size());
        end
        tick();
        total++;
        if (busy !== 1'b1 || pic_cs_n !== 1'b0 || pic_data !== 8'h13) begin
            bad++;
            $display("FAIL pend_icw1 busy=%b cs_n=%b data=%h need 1 0 13", busy, pic_cs_n, pic_data);
        end
        drain(n, dones, acks);
        total++;
        if (n != 18 || init_done !== 1'b1 || initialized !== 1'b1) begin
            bad++;
            $display("FAIL pend_init_done len=%0d done=%b init=%b need 18 1 1", n, init_done, initialized);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int s0, n;
        int cs_low = 0;
        set_cfg(1'b1, 1'b0, 1'b0, 5'h05, 8'h04, 1'b0, 1'b0);
        exp_q.push_back({1'b0, 8'h18});
        exp_q.push_back({1'b1, 8'h28});
        s0 = strobes;
        pulse_init();
        n = 0;
        while (strobes < s0 + 2 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (pic_wr_n !== 1'b0 || pic_a0 !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_in_icw2 wr_n=%b a0=%b need 0 1", pic_wr_n, pic_a0);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({pic_wr_n, pic_cs_n, pic_data_oe, busy, initialized} !== 5'b11000) begin
            bad++;
            $display("FAIL rst_mid_async got=%b need=11000", {pic_wr_n, pic_cs_n, pic_data_oe, busy, initialized});
        end
        exp_q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (10) begin
            tick();
            if (pic_cs_n !== 1'b1 || busy !== 1'b0) cs_low++;
        end
        total++;
        if (cs_low != 0 || initialized !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_idle active=%0d init=%b need 0 0", cs_low, initialized);
        end
    endtask

    initial begin
        reset_n = 1'b0; init_start = 1'b0;
        ocw_req = 1'b0; ocw_sel = 2'd0; ocw_data = 8'h00;
        set_cfg(1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_ocw_before_init();
        test_init_single();
        test_init_cascade();
        test_ocw_after_init();
        test_ocw_formats();
        test_init_ocw_tie();
        test_init_during_ocw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
